// File: rtl/fpu_norm_round_stage.sv
// Normalise-and-round stage for the pipelined FPU adder.
// Sub-stage 1 normalises the raw add/sub mantissa: a carry shifts right, leading
// zeros shift left as far as the exponent floor allows. Sub-stage 2 applies
// round-to-nearest-even, detects overflow/underflow/inexact and packs the fields.
//
// Handshake: a beat moves on a rising edge when its valid is high and the
// receiving side's ready is high. Valid never depends on ready. A stage can
// accept new data when it is empty or its content is leaving this cycle, so
// in_ready_o follows out_ready_i combinationally. Held outputs stay stable.
module fpu_norm_round_stage #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sign_i,
    input  logic [EXP_W-1:0]  in_exp_i,
    input  logic [MANT_W+4:0] in_mant_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sign_o,
    output logic [EXP_W-1:0]  out_exp_o,
    output logic [MANT_W-1:0] out_mant_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              inexact_o
);

    // Internal exponent carries two extra bits so +1 on an all-ones exponent
    // and subtraction of the shift amount never wrap.
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] E_ONE = EW2'(1);
    localparam logic signed [EW2-1:0] E_MAX = EW2'((1 << EXP_W) - 1);

    // Leading-zero count over {hidden, fraction}
    function automatic logic signed [EW2-1:0] lzc(input logic [MANT_W:0] v);
        logic signed [EW2-1:0] n;
        logic                  found;
        n     = '0;
        found = 1'b0;
        for (int i = MANT_W; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + E_ONE;
            end
        end
        return n;
    endfunction

    // Pipeline control
    logic adv1;
    logic adv2;
    logic v1;
    logic v2;

    assign adv2        = !v2 || out_ready_i;
    assign adv1        = !v1 || adv2;
    assign in_ready_o  = adv1;
    assign out_valid_o = v2;

    // Stage 1 state: {hidden, fraction} significand, GRS bits, exponent, sign
    logic                  s1_sign;
    logic signed [EW2-1:0] s1_exp;
    logic [MANT_W:0]       s1_sig;
    logic [2:0]            s1_grs;

    // Stage 1 next values
    logic                  n1_sign;
    logic signed [EW2-1:0] n1_exp;
    logic [MANT_W:0]       n1_sig;
    logic [2:0]            n1_grs;
    logic signed [EW2-1:0] in_exp_x;
    logic signed [EW2-1:0] lz;
    logic signed [EW2-1:0] lim;
    logic signed [EW2-1:0] sh;

    assign in_exp_x = signed'({2'b00, in_exp_i});

    // Normalise: right shift on carry, bounded left shift on leading zeros.
    // The left shift moves only {hidden, fraction}; the rounding bits stay in
    // place because a large cancellation only occurs with near-equal exponents.
    always_comb begin
        n1_sign = in_sign_i;
        n1_exp  = in_exp_x;
        n1_sig  = in_mant_i[MANT_W+3:3];
        n1_grs  = in_mant_i[2:0];
        lz      = '0;
        lim     = '0;
        sh      = '0;
        if (in_mant_i == '0) begin
            // exact cancellation yields +0
            n1_sign = 1'b0;
            n1_exp  = '0;
        end else if (in_mant_i[MANT_W+4]) begin
            n1_sig = in_mant_i[MANT_W+4:4];
            n1_grs = {in_mant_i[3], in_mant_i[2], in_mant_i[1] | in_mant_i[0]};
            n1_exp = in_exp_x + E_ONE;
        end else if (!in_mant_i[MANT_W+3]) begin
            lz = lzc(in_mant_i[MANT_W+3:3]);
            if (in_exp_i != '0) begin
                lim = in_exp_x - E_ONE;
                sh  = (lz < lim) ? lz : lim;
            end
            n1_sig = in_mant_i[MANT_W+3:3] << sh;
            n1_exp = in_exp_x - sh;
            // still no hidden bit: the value is subnormal
            if (!n1_sig[MANT_W]) n1_exp = '0;
        end
    end

    // Stage 1 register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_sig  <= '0;
            s1_grs  <= '0;
        end else if (adv1) begin
            v1 <= in_valid_i;
            if (in_valid_i) begin
                s1_sign <= n1_sign;
                s1_exp  <= n1_exp;
                s1_sig  <= n1_sig;
                s1_grs  <= n1_grs;
            end
        end
    end

    // Stage 2 next values
    logic                  inc;
    logic [MANT_W+1:0]     sum;
    logic signed [EW2-1:0] r_exp;
    logic [MANT_W-1:0]     r_frac;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_inx;

    // Round to nearest even, then saturate to infinity and derive flags
    always_comb begin
        inc    = s1_grs[2] && (s1_grs[1] || s1_grs[0] || s1_sig[0]);
        sum    = {1'b0, s1_sig} + {{(MANT_W+1){1'b0}}, inc};
        r_exp  = s1_exp;
        r_frac = sum[MANT_W-1:0];
        r_inx  = |s1_grs;
        r_ovf  = 1'b0;
        if (sum[MANT_W+1]) begin
            r_exp  = s1_exp + E_ONE;
            r_frac = '0;
        end else if (sum[MANT_W] && (s1_exp == '0)) begin
            // subnormal rounded up into the smallest normal
            r_exp = E_ONE;
        end
        if (r_exp >= E_MAX) begin
            r_exp  = E_MAX;
            r_frac = '0;
            r_ovf  = 1'b1;
            r_inx  = 1'b1;
        end
        r_unf = (r_exp == '0) && r_inx;
    end

    // Stage 2 register: outputs hold while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2          <= 1'b0;
            out_sign_o  <= 1'b0;
            out_exp_o   <= '0;
            out_mant_o  <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_sign_o  <= s1_sign;
                out_exp_o   <= r_exp[EXP_W-1:0];
                out_mant_o  <= r_frac;
                overflow_o  <= r_ovf;
                underflow_o <= r_unf;
                inexact_o   <= r_inx;
            end
        end
    end

endmodule

// File: tb/tb_fpu_norm_round_stage.sv
// Bench for fpu_norm_round_stage (EXP_W=8, MANT_W=23): directed corner cases,
// latency, back-pressure, mid-flight reset and randomized beats against a
// value-level reference model, with a queue-based scoreboard.
module tb_fpu_norm_round_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    // expected {sign, exp[7:0], frac[22:0], overflow, underflow, inexact}
    logic [34:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        bp_random = 1'b0;

    fpu_norm_round_stage #(.EXP_W(8), .MANT_W(23)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sign_i   (in_sign),
        .in_exp_i    (in_exp),
        .in_mant_i   (in_mant),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sign_o  (out_sign),
        .out_exp_o   (out_exp),
        .out_mant_o  (out_mant),
        .overflow_o  (overflow),
        .underflow_o (underflow),
        .inexact_o   (inexact)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: works on the significand as an integer value
    function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [27:0] m);
        int          sig;
        int          ex;
        int          g;
        int          r;
        int          st;
        int          inc;
        logic        inx;
        logic        ovf;
        logic        unf;
        logic [31:0] sig_b;
        logic [31:0] ex_b;
        if (m == 28'd0) return 35'd0;
        sig = int'(m[26:3]);
        g   = int'(m[2]);
        r   = int'(m[1]);
        st  = int'(m[0]);
        ex  = int'(e);
        if (m[27]) begin
            st  = st | r;
            r   = g;
            g   = sig % 2;
            sig = (sig / 2) + (1 << 23);
            ex  = ex + 1;
        end else if (sig < (1 << 23)) begin
            while (sig < (1 << 23) && ex > 1) begin
                sig = sig * 2;
                ex  = ex - 1;
            end
            if (sig < (1 << 23)) ex = 0;
        end
        inx = (g != 0) || (r != 0) || (st != 0);
        inc = (g != 0 && (r != 0 || st != 0 || (sig % 2) != 0)) ? 1 : 0;
        sig = sig + inc;
        if (sig >= (1 << 24)) begin
            sig = sig / 2;
            ex  = ex + 1;
        end else if (ex == 0 && sig >= (1 << 23)) begin
            ex = 1;
        end
        ovf = 1'b0;
        if (ex >= 255) begin
            ex  = 255;
            sig = 0;
            ovf = 1'b1;
            inx = 1'b1;
        end
        unf   = (ex == 0) && inx;
        sig_b = 32'(sig);
        ex_b  = 32'(ex);
        return {s, ex_b[7:0], sig_b[22:0], ovf, unf, inx};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Driver: called at posedge+1, returns at posedge+1 after the beat is taken
    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m, input logic [34:0] expv);
        int waits;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        end else begin
            exp_q.push_back(expv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    // Monitor / scoreboard: compares each beat the DUT hands downstream
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             {out_sign, out_exp, out_mant, overflow, underflow, inexact});
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({out_sign, out_exp, out_mant, overflow, underflow, inexact}), 64'(e));
                end
            end
        end
    end

    // Random back-pressure source
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Random beat generator covering carry, normal, cancellation, subnormal, near-overflow
    task automatic send_random();
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic [22:0] frac;
        logic [23:0] hf;
        logic [2:0]  grs;
        s    = 1'($urandom_range(0, 1));
        grs  = 3'($urandom_range(0, 7));
        frac = 23'($urandom);
        hf   = 24'($urandom) >> $urandom_range(1, 24);
        case ($urandom_range(0, 4))
            0: begin
                e = 8'($urandom_range(1, 254));
                m = {1'b1, 1'($urandom_range(0, 1)), frac, grs};
            end
            1: begin
                e = 8'($urandom_range(1, 254));
                m = {2'b01, frac, grs};
            end
            2: begin
                e = 8'($urandom_range(0, 254));
                m = {1'b0, hf, grs};
            end
            3: begin
                e = 8'($urandom_range(0, 6));
                m = {1'b0, hf, grs};
            end
            default: begin
                e = 8'($urandom_range(252, 254));
                m = {1'($urandom_range(0, 1)), 1'b1, 23'h7FFFFF ^ 23'($urandom_range(0, 3)), grs};
            end
        endcase
        send(s, e, m, model(s, e, m));
    endtask

    // Main sequence
    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_fields", 64'({out_sign, out_exp, out_mant}), 64'(0));
        check("rst_flags", 64'({overflow, underflow, inexact}), 64'(0));
        @(posedge clk);
        #1;

        // Latency of a single beat with no stall (carry case)
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_exp    = 8'h7F;
        in_mant   = {1'b1, 1'b1, 23'h0, 3'b000};
        @(negedge clk);
        check("lat_in_ready", 64'(in_ready), 64'(1));
        exp_q.push_back({1'b0, 8'h80, 23'h400000, 3'b000});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(2));
        drain();

        // Directed corners, back to back
        send(1'b1, 8'h85, {2'b00, 23'h000010, 3'b000}, {1'b1, 8'h72, 23'h000000, 3'b000});
        send(1'b0, 8'h7F, {2'b01, 23'h000001, 3'b100}, {1'b0, 8'h7F, 23'h000002, 3'b001});
        send(1'b0, 8'h7F, {2'b01, 23'h000002, 3'b100}, {1'b0, 8'h7F, 23'h000002, 3'b001});
        send(1'b0, 8'hFE, {2'b11, 23'h7FFFFF, 3'b000}, {1'b0, 8'hFF, 23'h000000, 3'b101});
        send(1'b0, 8'h03, {2'b00, 23'h000100, 3'b010}, {1'b0, 8'h00, 23'h000400, 3'b011});
        send(1'b1, 8'h90, 28'd0,                       {1'b0, 8'h00, 23'h000000, 3'b000});
        send(1'b0, 8'h80, {2'b01, 23'h7FFFFF, 3'b110}, {1'b0, 8'h81, 23'h000000, 3'b001});
        send(1'b0, 8'h00, {2'b00, 23'h7FFFFF, 3'b100}, {1'b0, 8'h01, 23'h000000, 3'b001});
        send(1'b1, 8'hFE, {2'b01, 23'h7FFFFF, 3'b110}, {1'b1, 8'hFF, 23'h000000, 3'b101});
        drain();

        // Back-pressure: 4 beats with downstream stalled 3 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 4; i++) send_random();
            end
            begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with a full pipeline drops the beats
        out_ready = 1'b0;
        send_random();
        send_random();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_fields", 64'({out_sign, out_exp, out_mant, overflow, underflow, inexact}), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Randomized beats with random back-pressure and idle gaps
        bp_random = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send_random();
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_random = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
